// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared FSM state encoding and default sizing for the branch resolver
package branch_resolver_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PREDICT, S_UPDATE, S_GAP} state_t;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/branch_resolver_pred_fifo.sv
// pred_fifo: 1-bit prediction queue with wrap-around pointers and whole-queue clear
module pred_fifo
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic                     din,
    output logic                     dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    assign dout = r_mem[r_rd];
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (pop) r_rd <= r_rd + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: queues predictor answers per fetched branch and checks them against resolved outcomes
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     br_valid,
    output logic                     br_ready,
    input  logic                     out_valid,
    input  logic                     out_taken,
    output logic                     out_ready,
    output logic                     request,
    output logic                     result,
    output logic                     taken,
    input  logic                     prediction,
    output logic                     pred_valid,
    output logic                     pred_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         miss_count
);
    localparam int OW = $clog2(DEPTH) + 1;
    state_t r_state;
    state_t w_next;
    logic   r_taken;
    logic   w_idle;
    logic   w_head;
    logic   w_out_acc;
    logic   w_br_acc;
    logic   w_miss;
    assign w_idle    = (r_state == S_IDLE);
    assign out_ready = w_idle && (outstanding != '0);
    // a pending outcome always beats a new branch for the idle slot
    assign br_ready  = w_idle && (outstanding != OW'(DEPTH)) && !(out_valid && out_ready);
    assign w_out_acc = out_valid && out_ready;
    assign w_br_acc  = br_valid && br_ready;
    assign w_miss    = w_out_acc && (w_head != out_taken);
    assign request   = (r_state == S_PREDICT);
    assign result    = (r_state == S_UPDATE);
    assign taken     = result && r_taken;
    always_comb begin
        w_next = r_state;
        if (w_idle)
            w_next = w_out_acc ? S_UPDATE : (w_br_acc ? S_PREDICT : S_IDLE);
        else
            w_next = (r_state == S_GAP) ? S_IDLE : S_GAP;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_taken    <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            r_state    <= w_next;
            pred_valid <= request;
            mispredict <= w_miss;
            if (request) pred_taken <= prediction;
            if (w_out_acc) r_taken <= out_taken;
            if (w_out_acc && !w_miss && !(&hit_count)) hit_count <= hit_count + CNT_W'(1);
            if (w_miss && !(&miss_count)) miss_count <= miss_count + CNT_W'(1);
        end
    end
    // a mispredict pops the head and squashes every younger entry in one step
    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (request),
        .pop   (w_out_acc),
        .clear (w_miss),
        .din   (prediction),
        .dout  (w_head),
        .count (outstanding)
    );
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter DEPTH, default 4, meaning max outstanding predicted branches (power of 2, >=2).
REQ-002 Parameter CNT_W, default 16, meaning width of statistics counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 br_valid  input  1  fetch presents a new branch.
REQ-006 br_ready  output  1  block accepts branch this cycle.
REQ-007 out_valid  input  1  execute presents resolved outcome of oldest outstanding branch.
REQ-008 out_taken  input  1  resolved direction, qualified by out_valid.
REQ-009 out_ready  output  1  block accepts outcome this cycle.
REQ-010 request  output  1  predictor query strobe.
REQ-011 result  output  1  predictor update strobe.
REQ-012 taken  output  1  actual direction sent with result.
REQ-013 prediction  input  1  predictor answer, valid while request high.
REQ-014 pred_valid  output  1  one-cycle pulse, pred_taken valid.
REQ-015 pred_taken  output  1  captured prediction for fetch.
REQ-016 mispredict  output  1  one-cycle pulse on wrong prediction.
REQ-017 outstanding  output  clog2(DEPTH)+1  queued predictions.
REQ-018 hit_count, miss_count  output  CNT_W each  correct/wrong prediction totals.

Function
REQ-019 FSM states IDLE, PREDICT, UPDATE, GAP; one predictor transaction per three cycles max.
REQ-020 br_ready = (state==IDLE) & (outstanding<DEPTH) & ~(out_valid & out_ready-eligible); out_ready = (state==IDLE) & (outstanding>0).
REQ-021 Simultaneous br_valid and out_valid in IDLE with outstanding>0: outcome wins, br_ready low.
REQ-022 Branch accepted at edge T: state PREDICT in cycle T+1 with request=1, result=0.
REQ-023 At edge ending PREDICT: prediction pushed into DEPTH-entry FIFO, pred_taken<=prediction, pred_valid=1 for cycle T+2, state GAP.
REQ-024 Outcome accepted at edge T: FIFO head popped, compared with out_taken; state UPDATE in T+1 with result=1, taken=out_taken, request=0.
REQ-025 Match: hit_count+1, mispredict stays 0; mismatch: miss_count+1, mispredict=1 in T+1.
REQ-026 Mismatch also discards all remaining FIFO entries at edge T (younger branches squashed); outstanding=0 in T+1; squashed entries never update predictor.
REQ-027 UPDATE -> GAP -> IDLE; GAP drives request=result=taken=0 so predictor strobes are separated by a low cycle.
REQ-028 request and result never high in same cycle; each high exactly one cycle per transaction.
REQ-029 taken held 0 whenever result=0.
REQ-030 Counters saturate at all-ones, no wrap.
REQ-031 FIFO pointers wrap modulo DEPTH; full at outstanding==DEPTH blocks branches; empty blocks outcomes.

Reset
REQ-032 rst high at an edge: state IDLE, FIFO empty, outstanding=0, counters 0, all outputs 0 except none; applies mid-transaction, aborting any strobe next cycle.
REQ-033 rst dominates all handshakes on the same edge.

Structure
REQ-034 Shared package holds FSM state enum (2-bit) and default DEPTH/CNT_W constants.
REQ-035 FIFO is sub-module pred_fifo (push, pop, clear, data 1 bit, count), instantiated once.

Verification
REQ-036 Reset, one branch with prediction=1, outcome taken=1 -> request pulse cycle 1, pred_valid/pred_taken=1 cycle 2, result=1 taken=1, hit_count=1, mispredict=0.
REQ-037 prediction=0, outcome taken=1 -> mispredict pulse, miss_count=1, result=1 taken=1.
REQ-038 Four branches, no outcomes -> outstanding=4, br_ready=0; fifth held until an outcome accepted.
REQ-039 Three queued predictions 1,1,1, first outcome taken=0 -> mispredict, outstanding 3->0, one result pulse only.
REQ-040 br_valid and out_valid together with outstanding=1 -> outcome first, branch accepted three cycles later.
REQ-041 rst asserted during PREDICT -> no pred_valid, outstanding=0, request=0 following cycle.
